game_tick_sequencer: RTL and testbench

//  Timing/sequencing controller that sits beside the snake game-state FSM.

---
 rtl/game_tick_sequencer.sv | 160 ++++++++++++++++
 tb/tb_game_tick_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_sequencer.sv
// game_tick_sequencer
//   Timing companion to the snake game-state FSM: debounces the push-button
//   into a single pulse, paces snake moves while the game runs, emits the
//   move -> check -> draw strobe train, and speeds the game up as it grows.
module game_tick_sequencer #(
  parameter logic [23:0] BASE_PERIOD     = 24'd2_500_000,
  parameter logic [23:0] STEP            = 24'd200_000,
  parameter logic [2:0]  MAX_LEVEL       = 3'd7,
  parameter logic [3:0]  GROWS_PER_LEVEL = 4'd4,
  parameter logic [15:0] DB_CYCLES       = 16'd50_000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       button_raw,
  input  logic [1:0] state,
  input  logic       grow,
  output logic       button_pulse,
  output logic       move_tick,
  output logic       check_strobe,
  output logic       draw_strobe,
  output logic [2:0] speed_level,
  output logic       clear_game
);

  localparam logic [1:0] RUN   = 2'b00;
  localparam logic [1:0] IDLE  = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] OVER  = 2'b11;

  logic        sync_p0, sync_p1;
  logic        db_level, db_level_d;
  logic [15:0] db_cnt;
  logic [23:0] tick_cnt;
  logic [23:0] period, period_m1;
  logic        frame_p0, frame_p1, frame_p2;
  logic [3:0]  grow_cnt;
  logic [1:0]  prev_state;
  logic        clear_cond;

  function automatic logic [2:0] sat_inc_level(input logic [2:0] lvl);
    return (lvl >= MAX_LEVEL) ? lvl : lvl + 3'd1;
  endfunction

  assign move_tick    = frame_p0;
  assign check_strobe = frame_p1;
  assign draw_strobe  = frame_p2;

  // Move period for the current speed level and the game-over -> idle detect.
  always_comb begin
    period     = BASE_PERIOD - (24'(speed_level) * STEP);
    period_m1  = period - 24'd1;
    clear_cond = (prev_state == OVER) && (state == IDLE);
  end

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= button_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debouncer: accept a new level only after it has differed long enough.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      db_cnt   <= 16'd0;
      db_level <= 1'b0;
    end else if (sync_p1 != db_level) begin
      if (db_cnt == DB_CYCLES - 16'd1) begin
        db_level <= sync_p1;
        db_cnt   <= 16'd0;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
    end else begin
      db_cnt <= 16'd0;
    end
  end

  // One-cycle pulse on the debounced rising edge.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      db_level_d   <= 1'b0;
      button_pulse <= 1'b0;
    end else begin
      db_level_d   <= db_level;
      button_pulse <= db_level & ~db_level_d;
    end
  end

  // Move pacing; >= lets a shortened period that overtakes the count fire at once.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      tick_cnt <= 24'd0;
      frame_p0 <= 1'b0;
    end else begin
      frame_p0 <= 1'b0;
      if (clear_cond) begin
        tick_cnt <= 24'd0;
      end else begin
        case (state)
          RUN: begin
            if (tick_cnt >= period_m1) begin
              tick_cnt <= 24'd0;
              frame_p0 <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 24'd1;
            end
          end
          PAUSE:   tick_cnt <= tick_cnt;
          default: tick_cnt <= 24'd0;
        endcase
      end
    end
  end

  // Frame strobe train; a started frame always completes unless reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      frame_p1 <= 1'b0;
      frame_p2 <= 1'b0;
    end else begin
      frame_p1 <= frame_p0;
      frame_p2 <= frame_p1;
    end
  end

  // Speed level: every GROWS_PER_LEVEL apples while running bumps the level.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      grow_cnt    <= 4'd0;
      speed_level <= 3'd0;
    end else if (clear_cond) begin
      grow_cnt    <= 4'd0;
      speed_level <= 3'd0;
    end else if ((state == RUN) && grow) begin
      if (grow_cnt == GROWS_PER_LEVEL - 4'd1) begin
        grow_cnt    <= 4'd0;
        speed_level <= sat_inc_level(speed_level);
      end else begin
        grow_cnt <= grow_cnt + 4'd1;
      end
    end
  end

  // Previous game state and the registered clear pulse.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      prev_state <= IDLE;
      clear_game <= 1'b0;
    end else begin
      prev_state <= state;
      clear_game <= clear_cond;
    end
  end

endmodule

// File: tb/tb_game_tick_sequencer.sv
// Bench for game_tick_sequencer with reduced timing parameters.
module tb_game_tick_sequencer;

  localparam int BASE = 20;
  localparam int STP  = 2;
  localparam int MAXL = 3;
  localparam int GPL  = 2;
  localparam int DB   = 4;

  logic       clk = 1'b0;
  logic       nrst;
  logic       button_raw;
  logic [1:0] state;
  logic       grow;
  logic       button_pulse, move_tick, check_strobe, draw_strobe, clear_game;
  logic [2:0] speed_level;

  int checks = 0;
  int errors = 0;

  game_tick_sequencer #(
    .BASE_PERIOD(24'd20), .STEP(24'd2), .MAX_LEVEL(3'd3),
    .GROWS_PER_LEVEL(4'd2), .DB_CYCLES(16'd4)
  ) dut (
    .clk(clk), .nrst(nrst), .button_raw(button_raw), .state(state), .grow(grow),
    .button_pulse(button_pulse), .move_tick(move_tick), .check_strobe(check_strobe),
    .draw_strobe(draw_strobe), .speed_level(speed_level), .clear_game(clear_game)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outputs derived from elapsed-cycle, grow-total and history rules.
  bit       m_hist1, m_hist2;
  bit       m_level, m_level_old;
  int       m_diff, m_elapsed, m_grows, m_per;
  logic [1:0] m_prev;
  bit       e_pulse, e_tick, e_check, e_draw, e_clear, m_clr, m_lv;
  int       e_level;

  always @(posedge clk) begin
    if (!nrst) begin
      m_hist1 = 0; m_hist2 = 0; m_level = 0; m_level_old = 0; m_diff = 0;
      m_elapsed = 0; m_grows = 0; m_prev = 2'b01;
      e_pulse = 0; e_tick = 0; e_check = 0; e_draw = 0; e_clear = 0; e_level = 0;
    end else begin
      e_draw  = e_check;
      e_check = e_tick;
      m_per   = BASE - e_level * STP;
      m_clr   = (m_prev == 2'b11) && (state == 2'b01);
      e_clear = m_clr;
      e_tick  = 0;
      if (state == 2'b00) begin
        m_elapsed++;
        if (m_elapsed >= m_per) begin
          e_tick = 1;
          m_elapsed = 0;
        end
      end else if (state != 2'b10) begin
        m_elapsed = 0;
      end
      if (state == 2'b00 && grow) m_grows++;
      if (m_clr) m_grows = 0;
      e_level = (m_grows / GPL > MAXL) ? MAXL : m_grows / GPL;
      m_lv = m_level;
      if (m_hist2 != m_level) begin
        m_diff++;
        if (m_diff == DB) begin
          m_level = m_hist2;
          m_diff = 0;
        end
      end else begin
        m_diff = 0;
      end
      e_pulse     = m_lv && !m_level_old;
      m_level_old = m_lv;
      m_hist2 = m_hist1;
      m_hist1 = button_raw;
      m_prev  = state;
    end
  end

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    chk("m_button_pulse", 32'(button_pulse), 32'(e_pulse));
    chk("m_move_tick",    32'(move_tick),    32'(e_tick));
    chk("m_check_strobe", 32'(check_strobe), 32'(e_check));
    chk("m_draw_strobe",  32'(draw_strobe),  32'(e_draw));
    chk("m_speed_level",  32'(speed_level),  32'(e_level));
    chk("m_clear_game",   32'(clear_game),   32'(e_clear));
  end

  task automatic do_reset(input logic [1:0] st);
    @(negedge clk);
    nrst = 1'b0; grow = 1'b0; button_raw = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1; state = st;
  endtask

  // Negedges until move_tick is seen, 0 if not seen within max.
  task automatic wait_tick(input int max, output int k);
    k = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (move_tick) begin
        k = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0] st;
    logic       g;
    logic [2:0] lvl;
  } spd_vec_t;

  spd_vec_t tbl [10];
  int k, pulses, ticks;

  initial begin
    tbl[0] = '{2'b00, 1'b1, 3'd0};
    tbl[1] = '{2'b00, 1'b1, 3'd1};
    tbl[2] = '{2'b01, 1'b1, 3'd1};
    tbl[3] = '{2'b00, 1'b0, 3'd1};
    tbl[4] = '{2'b00, 1'b1, 3'd1};
    tbl[5] = '{2'b00, 1'b1, 3'd2};
    tbl[6] = '{2'b00, 1'b1, 3'd2};
    tbl[7] = '{2'b00, 1'b1, 3'd3};
    tbl[8] = '{2'b00, 1'b1, 3'd3};
    tbl[9] = '{2'b00, 1'b1, 3'd3};

    nrst = 1'b0; state = 2'b01; grow = 1'b0; button_raw = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {26'd0, button_pulse, move_tick, check_strobe, draw_strobe,
                          clear_game, |speed_level}, 32'd0);

    // Move pacing and frame train after reset
    nrst = 1'b1; state = 2'b00;
    wait_tick(40, k);
    chk("first_tick_cycle", k, 20);
    @(negedge clk);
    chk("check_after_tick", {30'd0, move_tick, check_strobe}, 32'd1);
    @(negedge clk);
    chk("draw_after_check", {30'd0, check_strobe, draw_strobe}, 32'd1);
    wait_tick(40, k);
    chk("tick_repeat", k, 18);

    // Button glitches then a clean press
    do_reset(2'b01);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      button_raw = 1'b1; @(negedge clk); pulses += int'(button_pulse);
      button_raw = 1'b0; @(negedge clk); pulses += int'(button_pulse);
    end
    repeat (10) begin @(negedge clk); pulses += int'(button_pulse); end
    chk("glitch_no_pulse", pulses, 0);
    button_raw = 1'b1;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (button_pulse) begin k = i; break; end
    end
    chk("press_latency", k, 7);
    pulses = 0;
    repeat (10) begin @(negedge clk); pulses += int'(button_pulse); end
    button_raw = 1'b0;
    repeat (12) begin @(negedge clk); pulses += int'(button_pulse); end
    chk("press_single_pulse", pulses, 0);

    // Pause holds the count
    do_reset(2'b00);
    wait_tick(40, k);
    chk("pause_pre_tick", k, 20);
    repeat (10) @(negedge clk);
    state = 2'b10;
    ticks = 0;
    repeat (50) begin @(negedge clk); ticks += int'(move_tick); end
    chk("pause_no_tick", ticks, 0);
    state = 2'b00;
    wait_tick(40, k);
    chk("pause_resume_tick", k, 10);

    // Level 1 period
    do_reset(2'b00);
    repeat (2) begin grow = 1'b1; @(negedge clk); grow = 1'b0; @(negedge clk); end
    chk("level1", 32'(speed_level), 32'd1);
    wait_tick(40, k);
    wait_tick(40, k);
    chk("period_level1", k, 18);

    // Table-driven grow sequence
    do_reset(2'b00);
    for (int i = 0; i < 10; i++) begin
      state = tbl[i].st; grow = tbl[i].g;
      @(negedge clk);
      grow = 1'b0;
      @(negedge clk);
      chk($sformatf("grow_vec%0d", i), 32'(speed_level), 32'(tbl[i].lvl));
    end
    state = 2'b00;
    wait_tick(40, k);
    wait_tick(40, k);
    chk("period_level3", k, 14);

    // Game over -> idle clears
    state = 2'b11; @(negedge clk);
    state = 2'b01; @(negedge clk);
    chk("clear_pulse", 32'(clear_game), 32'd1);
    chk("clear_level", 32'(speed_level), 32'd0);
    @(negedge clk);
    chk("clear_one_cycle", 32'(clear_game), 32'd0);
    state = 2'b00;
    pulses = 0;
    repeat (6) begin @(negedge clk); pulses += int'(clear_game); end
    chk("idle_to_run_no_clear", pulses, 0);

    // Reset mid-frame aborts the strobes
    do_reset(2'b00);
    wait_tick(40, k);
    chk("midframe_tick", k, 20);
    nrst = 1'b0;
    @(negedge clk);
    chk("midframe_outputs", {26'd0, button_pulse, move_tick, check_strobe, draw_strobe,
                             clear_game, |speed_level}, 32'd0);
    nrst = 1'b1;
    pulses = 0;
    repeat (6) begin @(negedge clk); pulses += int'(check_strobe) + int'(draw_strobe); end
    chk("midframe_no_strobes", pulses, 0);

    // Randomized traffic, model-checked every cycle
    for (int i = 0; i < 4000; i++) begin
      nrst = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 29) == 0)
        state = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'($urandom_range(0, 3));
      grow = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) button_raw = ~button_raw;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
